// File: rtl/freq_pkg.sv
// Shared definitions for the frequency readout register bank: register map,
// FSM state encoding and channel sizing helper.
package freq_pkg;

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_SEQ     = 8'h02;
  localparam logic [7:0] ADDR_CH_BASE = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fsm_state_t;

  function automatic int bytes_per_ch(input int freq_w);
    return (freq_w + 7) / 8;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle rise and
// fall pulses derived from the synchronised value.
module sync_edge (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/freq_spi_regbank.sv
// Frequency result register bank: coherent snapshot of NUM_CH channel results
// served over a byte-level SPI slave with an auto-incrementing address.
module freq_spi_regbank
  import freq_pkg::*;
#(
  parameter int         NUM_CH  = 2,
  parameter int         FREQ_W  = 28,
  parameter logic [7:0] ID_BYTE = 8'hF1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_CH*FREQ_W-1:0] freq_in,
  input  logic                     calc_flag,
  input  logic                     spi_cs_n,
  input  logic                     rx_dv,
  input  logic [7:0]               rx_byte,
  output logic                     tx_dv,
  output logic [7:0]               tx_byte,
  output logic                     snap_valid
);

  localparam int BPC = bytes_per_ch(FREQ_W);

  fsm_state_t state, state_next;

  logic cf_sync, cf_rise, cf_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic unused_sync_bits;

  logic [NUM_CH-1:0][FREQ_W-1:0] shadow;
  logic [NUM_CH-1:0][FREQ_W-1:0] read_bank;
  logic [NUM_CH-1:0][8*BPC-1:0]  padded;

  logic [7:0] seq_cnt;
  logic [7:0] addr;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       pending;
  logic       overrun;
  logic       rx_accept;
  logic       publish;

  sync_edge u_sync_calc (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (calc_flag),
    .sync    (cf_sync),
    .rise    (cf_rise),
    .fall    (cf_fall)
  );

  sync_edge u_sync_cs (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (spi_cs_n),
    .sync    (cs_sync),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  assign unused_sync_bits = &{1'b0, cf_sync, cf_fall, cs_rise};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Entering a transaction needs a real CS falling edge, so a reset with CS
  // held low stays idle until the master reselects.
  always_comb begin
    state_next = state;
    rx_accept  = 1'b0;
    rd_addr    = addr;
    case (state)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (cs_sync) begin
          state_next = ST_IDLE;
        end else if (rx_dv) begin
          rx_accept  = 1'b1;
          rd_addr    = rx_byte;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cs_sync) begin
          state_next = ST_IDLE;
        end else if (rx_dv) begin
          rx_accept = 1'b1;
          rd_addr   = addr + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    padded = '0;
    for (int ch = 0; ch < NUM_CH; ch++) padded[ch][FREQ_W-1:0] = read_bank[ch];
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_ID:     rd_data = ID_BYTE;
      ADDR_STATUS: rd_data = {5'b0, pending, overrun, snap_valid};
      ADDR_SEQ:    rd_data = seq_cnt;
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          for (int k = 0; k < BPC; k++) begin
            if (rd_addr == 8'(int'(ADDR_CH_BASE) + ch * BPC + k))
              rd_data = padded[ch][k*8 +: 8];
          end
        end
      end
    endcase
  end

  // Publishing only while idle keeps a multi-byte read on one snapshot.
  assign publish = pending && (state == ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow     <= '0;
      read_bank  <= '0;
      seq_cnt    <= 8'h00;
      snap_valid <= 1'b0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      addr       <= 8'h00;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
    end else begin
      tx_dv <= rx_accept;
      if (rx_accept) begin
        addr    <= rd_addr;
        tx_byte <= rd_data;
      end
      if (cf_rise) shadow <= freq_in;
      if (publish) begin
        read_bank  <= shadow;
        seq_cnt    <= seq_cnt + 8'd1;
        snap_valid <= 1'b1;
      end
      if (cf_rise)      pending <= 1'b1;
      else if (publish) pending <= 1'b0;
      if (cf_rise && pending)                          overrun <= 1'b1;
      else if (rx_accept && (rd_addr == ADDR_STATUS))  overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_spi_regbank.sv
// Bench for freq_spi_regbank: an event-level model checked every cycle plus
// directed SPI reads with hand-computed register values.
module tb_freq_spi_regbank;

  localparam int NUM_CH = 2;
  localparam int FREQ_W = 28;
  localparam int BPC    = (FREQ_W + 7) / 8;

  logic                     sys_clk   = 1'b0;
  logic                     sys_rst   = 1'b1;
  logic [NUM_CH*FREQ_W-1:0] freq_in   = '0;
  logic                     calc_flag = 1'b0;
  logic                     spi_cs_n  = 1'b1;
  logic                     rx_dv     = 1'b0;
  logic [7:0]               rx_byte   = 8'h00;
  logic                     tx_dv;
  logic [7:0]               tx_byte;
  logic                     snap_valid;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  freq_spi_regbank #(
    .NUM_CH  (NUM_CH),
    .FREQ_W  (FREQ_W),
    .ID_BYTE (8'hF1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .freq_in    (freq_in),
    .calc_flag  (calc_flag),
    .spi_cs_n   (spi_cs_n),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .snap_valid (snap_valid)
  );

  always #5 sys_clk = ~sys_clk;

  // Model state: what the register map holds, not how the RTL stores it.
  bit         m_active, m_first, m_pending, m_overrun, m_valid;
  logic [7:0] m_addr, m_seq;
  logic [31:0] m_shadow [NUM_CH];
  logic [31:0] m_pub    [NUM_CH];
  logic [3:0] hist_cs, hist_cf;
  bit         exp_tx_dv;
  logic [7:0] exp_tx_byte;
  bit         exp_valid;

  function automatic logic [7:0] model_reg(input logic [7:0] a);
    int idx;
    if (a == 8'h00) return 8'hF1;
    if (a == 8'h01) return {5'b0, m_pending, m_overrun, m_valid};
    if (a == 8'h02) return m_seq;
    idx = int'(a) - 16;
    if (idx >= 0 && idx < NUM_CH * BPC)
      return 8'((m_pub[idx / BPC] >> (8 * (idx % BPC))) & 32'hFF);
    return 8'h00;
  endfunction

  // Inputs move at posedge+2, so at each posedge they hold the values of the
  // cycle that just ended; a 2-flop sync shows a raw sample two edges later.
  initial begin : model_proc
    logic [7:0] a;
    bit cs_high, cs_fall, cf_rise, do_pub, resp, pend_old;
    forever begin
      @(posedge sys_clk);
      if (sys_rst) begin
        m_active = 0; m_first = 0; m_pending = 0; m_overrun = 0; m_valid = 0;
        m_addr = 8'h00; m_seq = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
          m_shadow[c] = '0;
          m_pub[c]    = '0;
        end
        hist_cs = '0; hist_cf = '0;
        exp_tx_dv = 0; exp_tx_byte = 8'h00; exp_valid = 0;
      end else begin
        hist_cs  = {hist_cs[2:0], spi_cs_n};
        hist_cf  = {hist_cf[2:0], calc_flag};
        cs_high  = hist_cs[2];
        cs_fall  = !hist_cs[2] && hist_cs[3];
        cf_rise  = hist_cf[2] && !hist_cf[3];
        pend_old = m_pending;
        do_pub   = m_pending && !m_active;
        resp     = m_active && !cs_high && rx_dv;
        a        = m_first ? rx_byte : m_addr + 8'd1;
        exp_tx_dv = resp;
        if (resp) begin
          exp_tx_byte = model_reg(a);
          m_addr  = a;
          m_first = 0;
        end
        if (cf_rise && pend_old)      m_overrun = 1;
        else if (resp && a == 8'h01)  m_overrun = 0;
        if (do_pub) begin
          for (int c = 0; c < NUM_CH; c++) m_pub[c] = m_shadow[c];
          m_seq   = m_seq + 8'd1;
          m_valid = 1;
        end
        if (cf_rise) begin
          for (int c = 0; c < NUM_CH; c++) m_shadow[c] = 32'(freq_in[c*FREQ_W +: FREQ_W]);
          m_pending = 1;
        end else if (do_pub) begin
          m_pending = 0;
        end
        if (!m_active && cs_fall) begin
          m_active = 1;
          m_first  = 1;
        end else if (m_active && cs_high) begin
          m_active = 0;
        end
        exp_valid = m_valid;
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge sys_clk);
      if (chk_en) begin
        vectors++;
        if (tx_dv !== exp_tx_dv) begin
          miscompares++;
          $display("[TB] FAIL tx_dv @%0t actual=%0b expected=%0b", $time, tx_dv, exp_tx_dv);
        end
        vectors++;
        if (tx_byte !== exp_tx_byte) begin
          miscompares++;
          $display("[TB] FAIL tx_byte @%0t actual=%02h expected=%02h", $time, tx_byte, exp_tx_byte);
        end
        vectors++;
        if (snap_valid !== exp_valid) begin
          miscompares++;
          $display("[TB] FAIL snap_valid @%0t actual=%0b expected=%0b", $time, snap_valid, exp_valid);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%02h expected=%02h", name, actual, expected);
    end
  endtask

  // One SPI byte: rx_dv pulse, then a bounded wait for the tx_dv response.
  task automatic applyStimulus(input logic [7:0] b, output bit got, output logic [7:0] rsp);
    rx_byte = b;
    rx_dv   = 1'b1;
    wait_cycles(1);
    rx_dv = 1'b0;
    got   = 1'b0;
    rsp   = 8'h00;
    for (int i = 0; i < 4 && !got; i++) begin
      if (tx_dv) begin
        got = 1'b1;
        rsp = tx_byte;
      end else begin
        wait_cycles(1);
      end
    end
    wait_cycles(2);
  endtask

  task automatic readCheck(input string name, input logic [7:0] b, input logic [7:0] expected);
    bit got;
    logic [7:0] rsp;
    applyStimulus(b, got, rsp);
    checkOutput({name, "_dv"}, 8'(got), 8'h01);
    checkOutput(name, rsp, expected);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_cycles(5);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic pulse_calc();
    calc_flag = 1'b1;
    wait_cycles(4);
    calc_flag = 1'b0;
    wait_cycles(4);
  endtask

  initial begin : stim_proc
    bit got;
    logic [7:0] rsp;

    wait_cycles(3);
    chk_en = 1'b1;
    checkOutput("reset_tx_dv", 8'(tx_dv), 8'h00);
    checkOutput("reset_tx_byte", tx_byte, 8'h00);
    checkOutput("reset_snap_valid", 8'(snap_valid), 8'h00);
    sys_rst = 1'b0;
    wait_cycles(3);

    cs_low();
    readCheck("id", 8'h00, 8'hF1);
    readCheck("status_empty", 8'h01, 8'h00);
    cs_high();

    freq_in = {28'h1234567, 28'h0ABCDEF};
    pulse_calc();
    cs_low();
    readCheck("ch0_b0", 8'h10, 8'hEF);
    readCheck("ch0_b1", 8'h00, 8'hCD);
    readCheck("ch0_b2", 8'h00, 8'hAB);
    readCheck("ch0_b3", 8'h00, 8'h00);
    readCheck("ch1_b0", 8'h00, 8'h67);
    readCheck("ch1_b1", 8'h00, 8'h45);
    readCheck("ch1_b2", 8'h00, 8'h23);
    readCheck("ch1_b3", 8'h00, 8'h01);
    cs_high();
    cs_low();
    readCheck("seq1", 8'h02, 8'h01);
    cs_high();

    // Snapshot change mid-read stays deferred; wrap round to the status byte.
    cs_low();
    readCheck("old_b0", 8'h10, 8'hEF);
    readCheck("old_b1", 8'h00, 8'hCD);
    freq_in = {28'hFEDCBA9, 28'h7654321};
    pulse_calc();
    readCheck("old_b2", 8'h00, 8'hAB);
    readCheck("old_b3", 8'h00, 8'h00);
    readCheck("old_b4", 8'h00, 8'h67);
    readCheck("old_b5", 8'h00, 8'h45);
    readCheck("old_b6", 8'h00, 8'h23);
    readCheck("old_b7", 8'h00, 8'h01);
    for (int i = 0; i < 232; i++) applyStimulus(8'h00, got, rsp);
    readCheck("wrap_id", 8'h00, 8'hF1);
    readCheck("status_pending", 8'h00, 8'h05);
    cs_high();
    cs_low();
    readCheck("new_b0", 8'h10, 8'h21);
    readCheck("new_b1", 8'h00, 8'h43);
    readCheck("new_b2", 8'h00, 8'h65);
    readCheck("new_b3", 8'h00, 8'h07);
    readCheck("new_b4", 8'h00, 8'hA9);
    readCheck("new_b5", 8'h00, 8'hCB);
    readCheck("new_b6", 8'h00, 8'hED);
    readCheck("new_b7", 8'h00, 8'h0F);
    cs_high();
    cs_low();
    readCheck("seq2", 8'h02, 8'h02);
    cs_high();

    // Overrun read inside the transaction clears it.
    cs_low();
    pulse_calc();
    pulse_calc();
    readCheck("status_overrun", 8'h01, 8'h07);
    cs_high();
    cs_low();
    readCheck("status_cleared", 8'h01, 8'h01);
    cs_high();

    // Overrun not read inside the transaction survives the publish.
    cs_low();
    readCheck("seq3", 8'h02, 8'h03);
    pulse_calc();
    pulse_calc();
    readCheck("addr03", 8'h00, 8'h00);
    cs_high();
    cs_low();
    readCheck("status_ovr_kept", 8'h01, 8'h03);
    cs_high();
    cs_low();
    readCheck("status_again", 8'h01, 8'h01);
    cs_high();

    cs_low();
    readCheck("addr_ff", 8'hFF, 8'h00);
    readCheck("addr_ff_wrap_id", 8'h00, 8'hF1);
    readCheck("addr_ff_wrap_status", 8'h00, 8'h01);
    cs_high();

    // Reset in the middle of a read, with CS still low afterwards.
    cs_low();
    readCheck("pre_rst", 8'h10, 8'h21);
    rx_byte = 8'h00;
    rx_dv   = 1'b1;
    sys_rst = 1'b1;
    wait_cycles(1);
    checkOutput("rst_tx_dv", 8'(tx_dv), 8'h00);
    checkOutput("rst_snap_valid", 8'(snap_valid), 8'h00);
    rx_dv = 1'b0;
    wait_cycles(2);
    sys_rst = 1'b0;
    wait_cycles(3);
    applyStimulus(8'h02, got, rsp);
    checkOutput("no_resp_after_rst", 8'(got), 8'h00);
    cs_high();
    cs_low();
    readCheck("seq_after_rst", 8'h02, 8'h00);
    readCheck("addr03_after_rst", 8'h00, 8'h00);
    cs_high();

    wait_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/freq_spi_regbank.md
Name: freq_spi_regbank

Overview:
Parametrised successor to the frequency readout block: holds NUM_CH frequency results of FREQ_W bits, snapshots them coherently on the measurement-done flag, and serves them over a byte-level SPI slave interface.
- Protocol: first byte of a transaction = start address; each following byte returns the register at an auto-incrementing address.
- Fully synchronous to sys_clk. Adds features the previous version lacked:
  - flag synchronisation and edge detection
  - deferred snapshot during an active transaction
  - sequence counter, overrun flag and status/ID registers
- Sits between the frequency counter cores and the shared SPI slave byte engine.

Parameters:
NUM_CH, 2, number of frequency channels (1..8)
FREQ_W, 28, bits per channel result (1..32); BYTES_PER_CH = ceil(FREQ_W/8)
ID_BYTE, 8'hF1, constant returned at address 0x00

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, synchronous, active-high
freq_in  in  NUM_CH*FREQ_W  channel results, ch0 in LSBs; stable when calc_flag rises
calc_flag  in  1  measurement-done flag, asynchronous to sys_clk
spi_cs_n  in  1  SPI chip select pin, active-low, asynchronous
rx_dv  in  1  one-cycle pulse from the SPI byte engine: rx_byte is valid
rx_byte  in  8  received byte
tx_dv  out  1  one-cycle pulse: load tx_byte for the next SPI byte
tx_byte  out  8  byte to shift out next
snap_valid  out  1  high once at least one snapshot has been published

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge): all outputs 0, all registers 0, state IDLE, no pending snapshot. Reset mid-transaction aborts it; responses resume only after the next CS falling edge.
- calc_flag and spi_cs_n each pass through a 2-flop synchroniser. A calc_flag rise is one cycle where the synchronised value is 1 and the previous value was 0.
- Shadow capture: on every calc_flag rise, freq_in is copied into the shadow bank in that cycle.
- Overrun: if a capture occurs while a publish is still pending, set sticky status bit1 (overrun).
- Publish: copy shadow to the readout bank, increment seq_cnt (8-bit, wraps 0xFF->0x00), set snap_valid=1.
  - Publish occurs in the cycle after a capture if the FSM is IDLE.
  - Otherwise set pending and publish in the cycle after the FSM returns to IDLE.
  - A multi-byte read always sees one coherent snapshot.
- FSM:
  - IDLE: synchronised CS low -> ADDR.
  - ADDR: on rx_dv, addr <= rx_byte, go to DATA, and issue tx_dv with tx_byte = reg[rx_byte] one cycle after rx_dv.
  - DATA: on each rx_dv, addr <= addr+1 (8-bit wrap 0xFF->0x00), then tx_dv with reg[addr+1] one cycle later.
  - Any state: synchronised CS high -> IDLE, with no tx_dv.
  - Latency rx_dv -> tx_dv is exactly 1 cycle; tx_byte holds until the next tx_dv.
- Register map:
  - 0x00: ID_BYTE.
  - 0x01: status = {5'b0, pending, overrun, snap_valid}. Reading 0x01 (tx_dv issued with that address) clears overrun in the same cycle. A new overrun in the same cycle takes priority and keeps it set.
  - 0x02: seq_cnt.
  - 0x10 + ch*BYTES_PER_CH + k: byte k (little-endian) of channel ch. Bits above FREQ_W read 0.
  - All other addresses read 0x00.
- Simultaneous events:
  - Capture and CS-rise in the same cycle: the publish uses the new shadow.
  - rx_dv while in IDLE: ignored.

Decomposition:
- Shared package freq_pkg: ADDR_ID=8'h00, ADDR_STATUS=8'h01, ADDR_SEQ=8'h02, ADDR_CH_BASE=8'h10, FSM state encoding (IDLE/ADDR/DATA), function bytes_per_ch(FREQ_W).
- One sub-module, sync_edge: 2-flop synchroniser with rise/fall pulse outputs; instantiated for calc_flag and spi_cs_n.
- Register mux and FSM stay in the top module.

Test Plan:
- Reset, then CS low and send 0x00 -> tx_byte 0xF1; then send 0x01 -> tx_byte 0x00 (snap_valid=0).
- freq_in ch0=28'h0ABCDEF, ch1=28'h1234567; pulse calc_flag; read from 0x10 for 8 bytes -> EF CD AB 00 67 45 23 01; seq_cnt read = 0x01.
- With CS low and reading from 0x10, change freq_in and pulse calc_flag after 2 bytes -> remaining bytes are from the old snapshot; status shows pending=1. After CS high, a new read returns new values and seq_cnt=0x02.
- Two calc_flag pulses during one transaction -> status = 0x07. After CS high, read 0x01 -> 0x03 (overrun reported); read again -> 0x01.
- Start address 0xFF, three bytes read -> responses for 0xFF, 0x00, 0x01 = 0x00, 0xF1, status.
- Assert sys_rst mid-read -> tx_dv=0, snap_valid=0. Next transaction, reading 0x02 returns 0x00.
